pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the lab CPU fetch stage.
- Generates the instruction address each cycle and supports:
  - sequential increment
  - absolute and PC-relative branches
  - subroutine call/return through an internal return-address stack
  - stall, halt and soft re-init
- Drives the instruction ROM address and reports halt and stack-error status to the controller.

Parameters:
- ADDR_W, 8: PC / instruction address width in bits.
- STACK_DEPTH, 4: return-address stack entries (>=1).
- START_ADDR, 0: PC value after reset or init.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- init  in  1  synchronous restart: PC to START_ADDR, stack cleared, flags cleared, leave HALTED.
- halt  in  1  enter HALTED state.
- stall  in  1  hold PC and stack this cycle.
- branch_en  in  1  take a branch to the computed target.
- branch_rel  in  1  1 = target is PC + signed branch_target; 0 = absolute branch_target.
- branch_target  in  ADDR_W  absolute address or two's-complement offset.
- call  in  1  push PC+1, then jump to the computed target (branch_en not required).
- ret  in  1  pop the stack top into PC.
- pc_addr  out  ADDR_W  current instruction address (registered).
- halted  out  1  1 while in HALTED.
- stack_cnt  out  $clog2(STACK_DEPTH+1)  valid stack entries.
- stack_ovf  out  1  sticky: call attempted with stack full.
- stack_unf  out  1  sticky: ret attempted with stack empty.

Behaviour:
- Reset (RST_N low, async):
  - pc_addr = START_ADDR, halted = 0, stack_cnt = 0, stack_ovf = 0, stack_unf = 0, state = RUN.
- States:
  - RUN and HALTED.
  - RUN -> HALTED on halt.
  - HALTED -> RUN only on init.
  - In HALTED, every other input is ignored and the PC holds.
- Per-edge priority in RUN (highest first), exactly one action per cycle:
  1. init: PC = START_ADDR; stack emptied; flags cleared.
  2. halt: PC holds; halted = 1 from the next cycle.
  3. stall: PC, stack and flags hold.
  4. ret:
     - Stack non-empty: PC = top; stack_cnt decrements.
     - Stack empty: PC = PC+1; stack_unf set.
  5. call:
     - Push PC+1; PC = target.
     - If the stack is full: push dropped, stack_ovf set, jump still taken.
  6. branch_en: PC = target.
  7. Otherwise: PC = PC+1.
- init also applies while HALTED and takes priority there. It has the same effect as in RUN and returns the block to RUN.
- Target computation:
  - branch_rel = 0: target = branch_target.
  - branch_rel = 1: target = pc_addr + sign-extended branch_target, truncated to ADDR_W.
- All PC arithmetic wraps modulo 2^ADDR_W.
  - All-ones + 1 = 0.
  - Pushed return address wraps the same way.
- Latency:
  - pc_addr reflects a control input one cycle after that input is sampled.
  - No combinational path exists from inputs to outputs.
- Stack:
  - LIFO.
  - stack_cnt saturates at STACK_DEPTH and never goes below 0.
  - Contents are undefined above stack_cnt.
- Error flags are sticky until RST_N or init.

Decomposition:
- Package pc_pkg:
  - state enum {PC_RUN, PC_HALTED}
  - next-PC select enum {SEL_INIT, SEL_HOLD, SEL_RET, SEL_CALL, SEL_BRANCH, SEL_INC}
  - helper function for sign-extended relative add
- Sub-module ret_stack (params WIDTH, DEPTH):
  - Ports: CLK, RST_N, clr, push, pop, din, dout, cnt, full, empty.
  - Ignores push when full and pop when empty.
- pc_sequencer holds the FSM, the priority mux and the flags.

Test Plan:
- Reset release with no controls, 300 cycles, ADDR_W=8 -> pc_addr 0,1,2,...,255,0,...; wrap after 255.
- PC=10, branch_en=1, branch_rel=1, target=8'hFC -> next PC=6; branch_rel=0, target=0x40 -> next PC=0x40.
- From PC=5: call to 0x20 -> PC=0x20, stack_cnt=1. Then call to 0x30 (issued at PC 0x20) -> stack_cnt=2. Then ret, ret -> PC 0x21, then 6; stack_cnt=0.
- STACK_DEPTH=4: five consecutive calls -> stack_cnt=4, stack_ovf=1, fifth jump still taken. Ret with empty stack -> stack_unf=1, PC increments.
- halt at PC=0x12 -> PC holds 0x12, halted=1; branch/call in HALTED ignored. init -> PC=START_ADDR, halted=0, flags cleared.
- Both of these must hold:
  - stall together with branch_en -> PC holds.
  - RST_N asserted mid-call sequence -> immediate PC=START_ADDR, stack_cnt=0, no clock edge required.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
// Holds the FSM state, next-PC select codes and relative-add helper.
package pc_pkg;

  localparam int unsigned PC_MAX_W = 32;

  typedef enum logic {
    PC_RUN,
    PC_HALTED
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_INIT,
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_BRANCH,
    SEL_INC
  } pc_sel_t;

  // base + sign-extended off, where off is w bits wide.
  // The result is truncated to w bits (modulo 2^w).
  function automatic logic [PC_MAX_W-1:0] rel_add(
    input logic [PC_MAX_W-1:0] base,
    input logic [PC_MAX_W-1:0] off,
    input int unsigned         w
  );
    logic [PC_MAX_W-1:0] mask;
    logic [PC_MAX_W-1:0] ext;
    logic [PC_MAX_W-1:0] sb;
    if (w >= PC_MAX_W)
      mask = '1;
    else
      mask = (PC_MAX_W'(1) << w) - PC_MAX_W'(1);
    sb = (off >> (w - 1)) & PC_MAX_W'(1);
    if (sb != '0)
      ext = off | ~mask;
    else
      ext = off & mask;
    return (base + ext) & mask;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; top entry always sits in mem[0].
// Ports: CLK, RST_N, clr, push, pop, din, dout, cnt, full, empty.
module ret_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot, so push+pop on a full stack replaces the top.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[0];

  // Shift-register storage: no count-indexed addressing needed.
  always_ff @(posedge CLK) begin
    if (do_push && !do_pop) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        mem[i] <= mem[i-1];
    end else if (do_push && do_pop) begin
      mem[0] <= din;
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++)
        mem[i] <= mem[i+1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (do_push && !do_pop)
      cnt <= cnt + 1'b1;
    else if (do_pop && !do_push)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC generator: increment, branch, call/ret, halt.
// Ports: CLK, RST_N, init, halt, stall, branch_en, branch_rel,
//   branch_target, call, ret -> pc_addr, halted, stack_cnt,
//   stack_ovf, stack_unf. All outputs are registered.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter  int                ADDR_W      = 8,
  parameter  int                STACK_DEPTH = 4,
  parameter  logic [ADDR_W-1:0] START_ADDR  = '0,
  localparam int                CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              init,
  input  logic              halt,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_rel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  stack_cnt,
  output logic              stack_ovf,
  output logic              stack_unf
);

  pc_state_t         state;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_clr;
  logic              stk_push;
  logic              stk_pop;

  assign pc_inc = pc_addr + 1'b1;

  always_comb begin
    target = branch_target;
    if (branch_rel)
      target = ADDR_W'(rel_add(PC_MAX_W'(pc_addr),
                               PC_MAX_W'(branch_target),
                               ADDR_W));
  end

  // One action per cycle; several controls may be high together.
  always_comb begin
    sel = SEL_INC;
    if (state == PC_HALTED) begin
      sel = init ? SEL_INIT : SEL_HOLD;
    end else begin
      priority case (1'b1)
        init:      sel = SEL_INIT;
        halt:      sel = SEL_HOLD;
        stall:     sel = SEL_HOLD;
        ret:       sel = SEL_RET;
        call:      sel = SEL_CALL;
        branch_en: sel = SEL_BRANCH;
        default:   sel = SEL_INC;
      endcase
    end
  end

  assign stk_clr  = (sel == SEL_INIT);
  assign stk_push = (sel == SEL_CALL);
  assign stk_pop  = (sel == SEL_RET);

  ret_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .cnt   (stack_cnt),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_addr   <= START_ADDR;
      state     <= PC_RUN;
      halted    <= 1'b0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      unique case (sel)
        SEL_INIT: begin
          pc_addr   <= START_ADDR;
          state     <= PC_RUN;
          halted    <= 1'b0;
          stack_ovf <= 1'b0;
          stack_unf <= 1'b0;
        end
        SEL_HOLD: begin
          if (state == PC_RUN && halt) begin
            state  <= PC_HALTED;
            halted <= 1'b1;
          end
        end
        SEL_RET: begin
          if (stk_empty) begin
            pc_addr   <= pc_inc;
            stack_unf <= 1'b1;
          end else begin
            pc_addr <= stk_top;
          end
        end
        SEL_CALL: begin
          pc_addr <= target;
          if (stk_full)
            stack_ovf <= 1'b1;
        end
        SEL_BRANCH: pc_addr <= target;
        SEL_INC:    pc_addr <= pc_inc;
        default:    pc_addr <= pc_addr;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps then random
// traffic, compared against a queue-based reference model.
module tb_pc_sequencer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int M      = 1 << ADDR_W;
  localparam int START  = 0;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              init = 1'b0;
  logic              halt = 1'b0;
  logic              stall = 1'b0;
  logic              branch_en = 1'b0;
  logic              branch_rel = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              call = 1'b0;
  logic              ret = 1'b0;
  logic [ADDR_W-1:0] pc_addr;
  logic              halted;
  logic [2:0]        stack_cnt;
  logic              stack_ovf;
  logic              stack_unf;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .START_ADDR  (8'(START))
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .init          (init),
    .halt          (halt),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_rel    (branch_rel),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .pc_addr       (pc_addr),
    .halted        (halted),
    .stack_cnt     (stack_cnt),
    .stack_ovf     (stack_ovf),
    .stack_unf     (stack_unf)
  );

  int m_pc;
  int m_q[$];
  bit m_halted;
  bit m_ovf;
  bit m_unf;
  int total = 0;
  int bad = 0;

  function automatic int calc_target();
    int off;
    if (!branch_rel) return int'(branch_target);
    off = int'(branch_target);
    if (off >= M / 2) off = off - M;
    return ((m_pc + off) % M + M) % M;
  endfunction

  task automatic model_reset();
    m_pc = START;
    m_q.delete();
    m_halted = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step();
    int t;
    t = calc_target();
    if (init) begin
      model_reset();
    end else if (m_halted) begin
    end else if (halt) begin
      m_halted = 1;
    end else if (stall) begin
    end else if (ret) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_back();
      end else begin
        m_pc = (m_pc + 1) % M;
        m_unf = 1;
      end
    end else if (call) begin
      if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) % M);
      else m_ovf = 1;
      m_pc = t;
    end else if (branch_en) begin
      m_pc = t;
    end else begin
      m_pc = (m_pc + 1) % M;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"}, 32'(pc_addr), m_pc);
    chk({tag, ".halted"}, 32'(halted), int'(m_halted));
    chk({tag, ".cnt"}, 32'(stack_cnt), m_q.size());
    chk({tag, ".ovf"}, 32'(stack_ovf), int'(m_ovf));
    chk({tag, ".unf"}, 32'(stack_unf), int'(m_unf));
  endtask

  task automatic idle();
    init = 0; halt = 0; stall = 0; branch_en = 0;
    branch_rel = 0; branch_target = '0; call = 0; ret = 0;
  endtask

  task automatic cycle(string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_branch(bit rel, int tgt, string tag);
    idle(); branch_en = 1; branch_rel = rel;
    branch_target = 8'(tgt);
    cycle(tag);
  endtask

  task automatic do_call(int tgt, string tag);
    idle(); call = 1; branch_target = 8'(tgt);
    cycle(tag);
  endtask

  task automatic do_ret(string tag);
    idle(); ret = 1;
    cycle(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    RST_N = 1;

    idle();
    for (int i = 0; i < 300; i++) cycle("inc");
    chk("wrap_pc", 32'(pc_addr), 300 % M);

    do_branch(0, 10, "abs10");
    do_branch(1, 8'hFC, "rel_neg");
    chk("rel_branch", 32'(pc_addr), 6);
    do_branch(0, 8'h40, "abs40");
    chk("abs_branch", 32'(pc_addr), 8'h40);

    do_branch(0, 5, "abs5");
    do_call(8'h20, "call1");
    chk("call1_pc", 32'(pc_addr), 8'h20);
    chk("call1_cnt", 32'(stack_cnt), 1);
    do_call(8'h30, "call2");
    chk("call2_cnt", 32'(stack_cnt), 2);
    do_ret("ret1");
    chk("ret1_pc", 32'(pc_addr), 8'h21);
    do_ret("ret2");
    chk("ret2_pc", 32'(pc_addr), 6);
    chk("ret2_cnt", 32'(stack_cnt), 0);

    for (int i = 0; i < 5; i++) do_call(8'h50 + i, "call5");
    chk("ovf_cnt", 32'(stack_cnt), 4);
    chk("ovf_flag", 32'(stack_ovf), 1);
    chk("ovf_pc", 32'(pc_addr), 8'h54);

    idle(); init = 1; cycle("init1");
    do_ret("ret_empty");
    chk("unf_flag", 32'(stack_unf), 1);
    chk("unf_pc", 32'(pc_addr), 1);

    do_branch(0, 8'h12, "to12");
    idle(); halt = 1; cycle("halt");
    chk("halt_pc", 32'(pc_addr), 8'h12);
    chk("halt_flag", 32'(halted), 1);
    do_branch(0, 8'h40, "halt_br");
    do_call(8'h44, "halt_call");
    chk("halted_hold", 32'(pc_addr), 8'h12);
    idle(); init = 1; cycle("init2");
    chk("init_pc", 32'(pc_addr), START);
    chk("init_halted", 32'(halted), 0);
    chk("init_unf", 32'(stack_unf), 0);

    idle(); stall = 1; branch_en = 1; branch_target = 8'h33;
    cycle("stall_br");
    chk("stall_pc", 32'(pc_addr), START);

    for (int i = 0; i < 2000; i++) begin
      init       = ($urandom_range(0, 99) < 2);
      halt       = ($urandom_range(0, 99) < 3);
      stall      = ($urandom_range(0, 99) < 15);
      ret        = ($urandom_range(0, 99) < 20);
      call       = ($urandom_range(0, 99) < 20);
      branch_en  = ($urandom_range(0, 99) < 30);
      branch_rel = 1'($urandom_range(0, 1));
      branch_target = 8'($urandom_range(0, M - 1));
      cycle("rand");
    end

    idle(); init = 1; cycle("init3");
    do_call(8'h70, "pre_rst1");
    do_call(8'h71, "pre_rst2");
    RST_N = 0;
    #2;
    model_reset();
    check_all("async_rst");
    chk("async_pc", 32'(pc_addr), START);
    chk("async_cnt", 32'(stack_cnt), 0);
    #2;
    RST_N = 1;
    idle();
    cycle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
